// File: rtl/bitserial_pkg.sv
// rtl/bitserial_pkg.sv - shared opcode and FSM state definitions for the bit-serial core
package bitserial_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_LDI = 3'b110,
    OP_NOP = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  function automatic logic is_arith(input op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/bs_alu_slice.sv
// rtl/bs_alu_slice.sv - one-bit combinational ALU slice used once per EXEC cycle
module bs_alu_slice
  import bitserial_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  input  op_e  op,
  output logic r,
  output logic cout
);

  logic bx;

  always_comb begin
    r    = 1'b0;
    cout = 1'b0;
    // SUB reuses the adder on the inverted operand; the +1 comes from carry-in
    bx   = (op == OP_SUB) ? ~b : b;
    case (op)
      OP_ADD, OP_SUB: begin
        r    = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) | (bx & cin);
      end
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_XOR:         r = a ^ b;
      OP_MOV, OP_LDI: r = a;
      default:        r = 1'b0;
    endcase
  end

endmodule

// File: rtl/bitserial_core_p.sv
// rtl/bitserial_core_p.sv - bit-serial register-file processor core, one result bit per cycle
module bitserial_core_p
  import bitserial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [2:0]               op,
  input  logic [$clog2(NREGS)-1:0] rd,
  input  logic [$clog2(NREGS)-1:0] rs1,
  input  logic [$clog2(NREGS)-1:0] rs2,
  input  logic [WIDTH-1:0]         imm,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     flag_c,
  output logic                     flag_z,
  output logic                     flag_n
);

  localparam int RW = $clog2(NREGS);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e            state, state_n;
  op_e               op_q;
  logic [RW-1:0]     rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0]  imm_q;
  logic [CW-1:0]     cnt;
  logic              carry;
  logic [WIDTH-1:0]  acc, acc_next;
  logic [WIDTH-1:0]  regs [NREGS];
  logic              a_bit, b_bit, alu_r, alu_c;

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: if (start) state_n = ST_EXEC;
      ST_EXEC: begin
        busy = 1'b1;
        if (cnt == LAST_BIT) state_n = ST_WB;
      end
      ST_WB: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign a_bit    = (op_q == OP_LDI) ? imm_q[0] : regs[rs1_q][0];
  assign b_bit    = regs[rs2_q][0];
  assign acc_next = {alu_r, acc[WIDTH-1:1]};
  assign result   = acc;

  bs_alu_slice u_alu (
    .a    (a_bit),
    .b    (b_bit),
    .cin  (carry),
    .op   (op_q),
    .r    (alu_r),
    .cout (alu_c)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= ST_IDLE;
      op_q   <= OP_NOP;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      imm_q  <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      acc    <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
      flag_n <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: if (start) begin
          op_q  <= op_e'(op);
          rd_q  <= rd;
          rs1_q <= rs1;
          rs2_q <= rs2;
          imm_q <= imm;
          cnt   <= '0;
          carry <= (op_e'(op) == OP_SUB);
        end
        ST_EXEC: begin
          cnt <= (cnt == LAST_BIT) ? '0 : cnt + CW'(1);
          if (op_q != OP_NOP) begin
            acc   <= acc_next;
            carry <= alu_c;
            imm_q <= imm_q >> 1;
            // full-width rotation restores the sources by the last bit cycle
            regs[rs1_q] <= {regs[rs1_q][0], regs[rs1_q][WIDTH-1:1]};
            if (rs2_q != rs1_q)
              regs[rs2_q] <= {regs[rs2_q][0], regs[rs2_q][WIDTH-1:1]};
            if (cnt == LAST_BIT) begin
              flag_c <= is_arith(op_q) & alu_c;
              flag_z <= (acc_next == '0);
              flag_n <= acc_next[WIDTH-1];
            end
          end
        end
        ST_WB: if (op_q != OP_NOP) regs[rd_q] <= acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bitserial_core_p.sv
// tb/tb_bitserial_core_p.sv - self-checking bench for bitserial_core_p (WIDTH=8 and WIDTH=16 instances)
module tb_bitserial_core_p;
  import bitserial_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn, start;
  logic [2:0] op;
  logic [1:0] rd, rs1, rs2;
  logic [7:0] imm;
  logic       busy, done, flag_c, flag_z, flag_n;
  logic [7:0] result;

  logic        start16;
  logic [2:0]  op16;
  logic [2:0]  rd16, rs1_16, rs2_16;
  logic [15:0] imm16;
  logic        busy16, done16, fc16, fz16, fn16;
  logic [15:0] result16;

  bitserial_core_p #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .busy(busy), .done(done), .result(result),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n)
  );

  bitserial_core_p #(.WIDTH(16), .NREGS(8)) dut16 (
    .clk(clk), .rstn(rstn), .start(start16), .op(op16), .rd(rd16), .rs1(rs1_16), .rs2(rs2_16),
    .imm(imm16), .busy(busy16), .done(done16), .result(result16),
    .flag_c(fc16), .flag_z(fz16), .flag_n(fn16)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Architectural model: register values and flags from plain arithmetic
  logic [7:0] mreg [4];
  logic [7:0] mres;
  logic       mc, mz, mn;

  task automatic model_apply(input logic [2:0] o, input logic [1:0] d, s1, s2, input logic [7:0] im);
    logic [8:0] wide;
    logic [7:0] a, b, v;
    logic       c;
    a = mreg[s1];
    b = mreg[s2];
    c = 1'b0;
    v = 8'h00;
    case (o)
      3'b000: begin wide = {1'b0, a} + {1'b0, b};        v = wide[7:0]; c = wide[8]; end
      3'b001: begin wide = {1'b0, a} + {1'b0, ~b} + 9'd1; v = wide[7:0]; c = wide[8]; end
      3'b010: v = a & b;
      3'b011: v = a | b;
      3'b100: v = a ^ b;
      3'b101: v = a;
      3'b110: v = im;
      default: return;
    endcase
    mreg[d] = v;
    mres = v;
    mc = c;
    mz = (v == 8'h00);
    mn = v[7];
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mreg[i] = 8'h00;
    mres = 8'h00;
    mc = 1'b0;
    mz = 1'b0;
    mn = 1'b0;
  endtask

  // Issue one instruction from IDLE; inputs are scrambled after acceptance
  task automatic run(input logic [2:0] o, input logic [1:0] d, s1, s2, input logic [7:0] im,
                     output logic [7:0] r, output logic [2:0] f);
    int lat;
    @(negedge clk);
    op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; start = 1'b1;
    @(posedge clk);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        op = 3'($urandom()); rd = 2'($urandom()); rs1 = 2'($urandom());
        rs2 = 2'($urandom()); imm = 8'($urandom());
      end
      if (done) begin lat = k; break; end
    end
    check("done_latency", 32'(lat), 32'(W + 1));
    r = result;
    f = {flag_c, flag_z, flag_n};
    @(negedge clk);
    check("done_one_pulse", 32'(done), 32'd0);
    check("idle_not_busy", 32'(busy), 32'd0);
  endtask

  task automatic run16(input logic [2:0] o, input logic [2:0] d, s1, s2, input logic [15:0] im,
                       output int lat);
    @(negedge clk);
    op16 = o; rd16 = d; rs1_16 = s1; rs2_16 = s2; imm16 = im; start16 = 1'b1;
    @(posedge clk);
    lat = 99;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start16 = 1'b0;
      if (done16) begin lat = k; break; end
    end
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd, rs1, rs2;
    logic [7:0] imm;
    logic [7:0] res;
    logic [2:0] czn;
  } vec_t;

  vec_t tbl [$];

  initial begin
    logic [7:0] r;
    logic [2:0] f;
    logic [2:0] o;
    logic [1:0] d, s1, s2;
    logic [7:0] im;
    int         ndone, last, lat;

    rstn = 1'b0; start = 1'b0; op = 3'b111; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
    start16 = 1'b0; op16 = 3'b111; rd16 = 0; rs1_16 = 0; rs2_16 = 0; imm16 = 0;
    model_reset();

    tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 8'h5A, 8'h5A, 3'b000});
    tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 8'hFF, 8'hFF, 3'b001});
    tbl.push_back('{OP_LDI, 2'd2, 2'd0, 2'd0, 8'h01, 8'h01, 3'b000});
    tbl.push_back('{OP_ADD, 2'd3, 2'd1, 2'd2, 8'h00, 8'h00, 3'b110});
    tbl.push_back('{OP_MOV, 2'd0, 2'd1, 2'd0, 8'h00, 8'hFF, 3'b001});
    tbl.push_back('{OP_MOV, 2'd0, 2'd2, 2'd0, 8'h00, 8'h01, 3'b000});
    tbl.push_back('{OP_LDI, 2'd1, 2'd0, 2'd0, 8'h03, 8'h03, 3'b000});
    tbl.push_back('{OP_LDI, 2'd2, 2'd0, 2'd0, 8'h05, 8'h05, 3'b000});
    tbl.push_back('{OP_SUB, 2'd1, 2'd1, 2'd2, 8'h00, 8'hFE, 3'b001});
    tbl.push_back('{OP_MOV, 2'd0, 2'd1, 2'd0, 8'h00, 8'hFE, 3'b001});
    tbl.push_back('{OP_NOP, 2'd1, 2'd2, 2'd2, 8'h77, 8'hFE, 3'b001});
    tbl.push_back('{OP_SUB, 2'd3, 2'd2, 2'd2, 8'h00, 8'h00, 3'b110});
    tbl.push_back('{OP_AND, 2'd0, 2'd1, 2'd2, 8'h00, 8'h04, 3'b000});
    tbl.push_back('{OP_OR,  2'd0, 2'd1, 2'd2, 8'h00, 8'hFF, 3'b001});
    tbl.push_back('{OP_XOR, 2'd0, 2'd1, 2'd2, 8'h00, 8'hFB, 3'b001});
    tbl.push_back('{OP_ADD, 2'd2, 2'd2, 2'd2, 8'h00, 8'h0A, 3'b000});
    tbl.push_back('{OP_MOV, 2'd0, 2'd2, 2'd0, 8'h00, 8'h0A, 3'b000});
    tbl.push_back('{OP_LDI, 2'd3, 2'd0, 2'd0, 8'h00, 8'h00, 3'b010});
    tbl.push_back('{OP_SUB, 2'd0, 2'd2, 2'd1, 8'h00, 8'h0C, 3'b000});

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      run(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm, r, f);
      check($sformatf("tbl%0d_result", i), 32'(r), 32'(tbl[i].res));
      check($sformatf("tbl%0d_czn", i), 32'(f), 32'(tbl[i].czn));
      model_apply(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
    end

    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom()); d = 2'($urandom()); s1 = 2'($urandom());
      s2 = 2'($urandom()); im = 8'($urandom());
      run(o, d, s1, s2, im, r, f);
      model_apply(o, d, s1, s2, im);
      check($sformatf("rnd%0d_result op%0d", i, o), 32'(r), 32'(mres));
      check($sformatf("rnd%0d_czn op%0d", i, o), 32'(f), 32'({mc, mz, mn}));
    end

    // start held high: one ADD completes every WIDTH+2 cycles, none queued
    @(negedge clk);
    op = 3'b000; rd = 2'd1; rs1 = 2'd1; rs2 = 2'd2; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    last = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 40) start = 1'b0;
      if (done) begin
        ndone++;
        if (last < 0) check("b2b_first_done", 32'(k), 32'(W + 1));
        else check("b2b_spacing", 32'(k - last), 32'(W + 2));
        last = k;
        model_apply(3'b000, 2'd1, 2'd1, 2'd2, 8'h00);
        check("b2b_result", 32'(result), 32'(mres));
      end
    end
    check("b2b_count", 32'(ndone), 32'd4);
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);

    // reset during bit cycle 4 of an ADD
    run(3'b110, 2'd1, 2'd0, 2'd0, 8'hA5, r, f);
    run(3'b110, 2'd2, 2'd0, 2'd0, 8'h3C, r, f);
    @(negedge clk);
    op = 3'b000; rd = 2'd3; rs1 = 2'd1; rs2 = 2'd2; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rstn = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    rstn = 1'b1;
    model_reset();
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    for (int i = 0; i < 4; i++) begin
      run(3'b101, 2'd0, 2'(i), 2'd0, 8'h00, r, f);
      model_apply(3'b101, 2'd0, 2'(i), 2'd0, 8'h00);
      check($sformatf("abort_reg%0d", i), 32'(r), 32'(mres));
      check($sformatf("abort_reg%0d_z", i), 32'(f[1]), 32'd1);
    end

    // WIDTH=16, NREGS=8 instance
    run16(3'b110, 3'd5, 3'd0, 3'd0, 16'h8000, lat);
    check("w16_ldi_latency", 32'(lat), 32'd17);
    check("w16_ldi_result", 32'(result16), 32'h8000);
    check("w16_ldi_n", 32'(fn16), 32'd1);
    run16(3'b110, 3'd6, 3'd0, 3'd0, 16'h8000, lat);
    run16(3'b000, 3'd7, 3'd5, 3'd6, 16'h0000, lat);
    check("w16_add_latency", 32'(lat), 32'd17);
    check("w16_add_result", 32'(result16), 32'h0000);
    check("w16_add_czn", 32'({fc16, fz16, fn16}), 32'b110);
    @(negedge clk);
    run16(3'b101, 3'd0, 3'd7, 3'd0, 16'hFFFF, lat);
    check("w16_r7", 32'(result16), 32'h0000);
    @(negedge clk);
    run16(3'b101, 3'd0, 3'd5, 3'd0, 16'hFFFF, lat);
    check("w16_r5_kept", 32'(result16), 32'h8000);
    check("w16_busy_end", 32'(busy16), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bitserial_core_p.md
BITSERIAL_CORE_P -- requirements
Module: bitserial_core_p

Interface
REQ-001 Parameter WIDTH, default 8, datapath and register width in bits; legal range 4..32.
REQ-002 Parameter NREGS, default 4, number of general registers; power of two, 2..16.
REQ-003 Clock, reset: clk; rstn, synchronous, active-low.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 start  input  1  instruction request; sampled only in IDLE.
REQ-007 op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 MOV, 110 LDI, 111 NOP.
REQ-008 rd, rs1, rs2  input  log2(NREGS) each  destination and source register indices.
REQ-009 imm  input  WIDTH  immediate operand for LDI.
REQ-010 busy  output  1  high in EXEC and WB.
REQ-011 done  output  1  one-cycle pulse in WB.
REQ-012 result  output  WIDTH  accumulator contents; holds the last computed value.
REQ-013 flag_c, flag_z, flag_n  output  1 each  carry/no-borrow, zero, negative flags.

Function
REQ-014 The FSM SHALL have states IDLE, EXEC and WB: IDLE->EXEC on start; EXEC->WB after WIDTH bit cycles; WB->IDLE unconditionally.
REQ-015 On the cycle start is accepted, op, rd, rs1, rs2 and imm SHALL be latched; later input changes have no effect until the next IDLE.
REQ-016 EXEC SHALL process exactly one bit per cycle, LSB first, using a bit counter that clears on acceptance and wraps after WIDTH-1.
REQ-017 Each EXEC cycle, registers rs1 and rs2 SHALL rotate right by one (a single rotation when rs1==rs2), so sources return to their original values at EXEC end.
REQ-018 Each EXEC cycle, the ALU result bit SHALL shift into the accumulator MSB while the accumulator shifts right; the latched imm SHALL shift out LSB first for LDI.
REQ-019 Carry SHALL initialise to 0 for ADD and to 1 for SUB, and SUB SHALL compute rs1 + ~rs2 + 1.
REQ-020 In WB, the accumulator SHALL be copied in parallel to rd for all ops except NOP, and done SHALL pulse.
REQ-021 In WB, flag_c SHALL be the final carry for ADD/SUB and 0 for logic, MOV and LDI; flag_z SHALL be 1 iff all result bits are 0; flag_n SHALL be the result MSB.
REQ-022 NOP SHALL take the same WIDTH+1 busy cycles but SHALL leave the registers, accumulator and flags unchanged.
REQ-023 done SHALL rise exactly WIDTH+1 cycles after the start-acceptance edge, and back-to-back instructions SHALL issue no faster than one every WIDTH+2 cycles.
REQ-024 start asserted while busy SHALL be ignored and not queued.
REQ-025 rd equal to rs1 or rs2 SHALL produce the result computed from the pre-instruction source values.

Reset
REQ-026 rstn low SHALL force IDLE, busy=0, done=0, result=0, all flags 0, all registers 0 and the counter to 0, including when asserted mid-EXEC or in WB.
REQ-027 An instruction aborted by reset SHALL produce no done pulse and no register write.

Structure
REQ-028 The opcode encodings and the state enumeration SHALL be defined in the shared package bitserial_pkg.
REQ-029 The combinational per-bit ALU SHALL be a separate sub-module, bs_alu_slice (inputs a, b, cin, op; outputs r, cout).
REQ-030 The register file and the accumulator SHALL be contained in bitserial_core_p; no memory macro.

Verification
REQ-031 WIDTH=8: reset, then LDI r1=0x5A -> done 9 cycles after acceptance, result=0x5A, Z=0, N=0, C=0.
REQ-032 r1=0xFF, r2=0x01, ADD r3=r1+r2 -> result=0x00, C=1, Z=1, N=0; r1 and r2 unchanged.
REQ-033 r1=0x03, r2=0x05, SUB r1=r1-r2 -> r1=0xFE, C=0, N=1, Z=0.
REQ-034 start held high for 40 cycles with ADDs -> one done every 10 cycles, with no missed or extra instructions.
REQ-035 rstn low at EXEC bit cycle 4 -> the next cycle shows busy=0, result=0 and all registers 0, with no done pulse.
REQ-036 WIDTH=16, NREGS=8: ADD r7 = 0x8000 + 0x8000 -> result=0x0000, C=1, Z=1, done at cycle 17.
